blink_scheduler: RTL and testbench

- Shares the single front-panel indicator LED among NUM_REQ requesters (alarm, timer expiry, set mode, ...).
- Each requester asks for a burst of blinks with its own half-period and blink count.
- The block arbitrates round-robin, times the on/off phases from an internal tick prescaler, and reports completion.
- It sits between the timekeeping/control FSMs and the LED output pin.

---
 rtl/blink_pkg.sv | 20 ++
 rtl/tick_prescaler.sv | 32 +++
 rtl/blink_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_blink_scheduler.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/blink_pkg.sv
// Shared definitions for the front-panel LED blink scheduler.
//   blink_state_e : scheduler FSM states
//   HP_W_DEF      : default half-period field width (ticks)
//   CNT_W_DEF     : default blink-count field width
//   SIM_TICK_DIV  : short prescaler ratio used in simulation
package blink_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ON,
    OFF,
    DONE,
    GAP
  } blink_state_e;

  localparam int HP_W_DEF     = 8;
  localparam int CNT_W_DEF    = 4;
  localparam int SIM_TICK_DIV = 4;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running timing-tick prescaler.
// Counts 0..TICK_DIV-1 and wraps; tick is high for the single cycle in
// which the count sits at TICK_DIV-1.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count returns to 0)
//   tick  : one-cycle timing strobe
module tick_prescaler #(
  parameter int TICK_DIV = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/blink_scheduler.sv
// Round-robin scheduler sharing one indicator LED among NUM_REQ requesters.
// Each grant latches the owner's half-period and blink count, then drives
// ON/OFF phases timed in prescaler ticks, pulses done for counted bursts,
// and holds a dark GAP before the next arbitration.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-requester level request
//   half_period  : per-requester phase length in ticks (slice i = requester i)
//   blinks       : per-requester blink count (0 = continuous while held)
//   grant        : one-hot owner, zero when nobody owns the LED
//   busy         : high in ON, OFF, DONE and GAP
//   led          : indicator drive
//   done/done_id : one-cycle completion pulse and completing requester index
module blink_scheduler
  import blink_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TICK_DIV  = 100000,
  parameter int HP_W      = HP_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int GAP_TICKS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*HP_W-1:0]      half_period,
  input  logic [NUM_REQ*CNT_W-1:0]     blinks,
  output logic [NUM_REQ-1:0]           grant,
  output logic                         busy,
  output logic                         led,
  output logic                         done,
  output logic [$clog2(NUM_REQ)-1:0]   done_id
);

  localparam int IDX_W    = $clog2(NUM_REQ);
  localparam int GW       = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_TICKS > 1) ? GAP_TICKS - 1 : 0);

  blink_state_e         state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_q, rr_d;
  logic [HP_W-1:0]      hp_q, hp_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [HP_W-1:0]      phase_q, phase_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 led_q, led_d;
  logic                 done_q, done_d;
  logic [IDX_W-1:0]     done_id_q, done_id_d;

  logic                 tick;
  logic [IDX_W:0]       pick;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     owner_next;
  logic [HP_W-1:0]      hp_arr  [NUM_REQ];
  logic [CNT_W-1:0]     cnt_arr [NUM_REQ];

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // First requesting index at or after ptr, wrapping; MSB flags a hit.
  // Scanning from the far end lets the nearest hit overwrite the others.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                             input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] ix;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      ix = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (r[ix]) res = {1'b1, ix};
    end
    return res;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      hp_arr[i]  = half_period[i*HP_W +: HP_W];
      cnt_arr[i] = blinks[i*CNT_W +: CNT_W];
    end
  end

  assign pick       = rr_pick(req, rr_q);
  assign pick_idx   = pick[IDX_W-1:0];
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_d      = rr_q;
    hp_d      = hp_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    gap_d     = gap_q;
    led_d     = led_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;

    case (state_q)
      IDLE: begin
        if (pick[IDX_W]) begin
          owner_d = pick_idx;
          grant_d = NUM_REQ'(1) << pick_idx;
          // A zero half-period would never terminate a phase; run it as 1.
          hp_d    = (hp_arr[pick_idx] == '0) ? HP_W'(1) : hp_arr[pick_idx];
          cnt_d   = cnt_arr[pick_idx];
          phase_d = '0;
          led_d   = 1'b1;
          state_d = ON;
        end
      end

      ON, OFF: begin
        if (!req[owner_q]) begin
          // Owner withdrew: go dark immediately, no completion report.
          led_d   = 1'b0;
          grant_d = '0;
          gap_d   = '0;
          rr_d    = owner_next;
          state_d = GAP;
        end else if (tick) begin
          if (phase_q == hp_q - 1'b1) begin
            phase_d = '0;
            if (state_q == ON) begin
              led_d   = 1'b0;
              state_d = OFF;
            end else if (cnt_q == '0) begin
              led_d   = 1'b1;
              state_d = ON;
            end else begin
              cnt_d = cnt_q - 1'b1;
              if (cnt_q == CNT_W'(1)) begin
                done_d    = 1'b1;
                done_id_d = owner_q;
                state_d   = DONE;
              end else begin
                led_d   = 1'b1;
                state_d = ON;
              end
            end
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end

      DONE: begin
        grant_d = '0;
        gap_d   = '0;
        rr_d    = owner_next;
        state_d = GAP;
      end

      GAP: begin
        if (tick) begin
          if (gap_q == GAP_LAST) state_d = IDLE;
          else                   gap_d   = gap_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_q      <= '0;
      phase_q   <= '0;
      gap_q     <= '0;
      led_q     <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      phase_q   <= phase_d;
      gap_q     <= gap_d;
      led_q     <= led_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  // Burst parameters are only meaningful while a grant is held.
  always_ff @(posedge clk) begin
    owner_q <= owner_d;
    hp_q    <= hp_d;
    cnt_q   <= cnt_d;
  end

  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign led     = led_q;
  assign done    = done_q;
  assign done_id = done_id_q;

endmodule

// File: tb/tb_blink_scheduler.sv
module tb_blink_scheduler;
  import blink_pkg::*;

  localparam int NR = 4;

  typedef struct {
    logic [3:0] req;
    int         hp;
    int         b;
    int         ngr;
  } vec_t;

  typedef struct {
    int id;
    int lo;
    int hi;
  } dexp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [NR-1:0]    req = '0;
  logic [NR*8-1:0]  half_period = '0;
  logic [NR*4-1:0]  blinks = '0;
  logic [NR-1:0]    grant;
  logic             busy, led, done;
  logic [1:0]       done_id;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_grant = 0;
  int n_done = 0;
  int grant_cyc = 0;
  int rr_m = 0;
  logic [NR-1:0] prev_grant = '0;

  int    exp_grant_q[$];
  dexp_t exp_done_q[$];

  blink_scheduler #(
    .NUM_REQ(NR), .TICK_DIV(SIM_TICK_DIV), .HP_W(8), .CNT_W(4), .GAP_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .half_period(half_period),
    .blinks(blinks), .grant(grant), .busy(busy), .led(led), .done(done),
    .done_id(done_id)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(string nm, int act, int lo, int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s got %0d expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // One clock: sample on the falling edge and score grant/done events.
  task automatic step();
    int    o;
    dexp_t d;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      prev_grant = '0;
    end else begin
      if (grant != prev_grant && grant != '0) begin
        n_grant++;
        grant_cyc = cyc;
        chk("grant_onehot", $countones(grant), 1);
        if (exp_grant_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_grant got %b expected none", grant);
        end else begin
          o = exp_grant_q.pop_front();
          chk("grant_owner", int'(grant), 1 << o);
        end
      end
      if (done) begin
        n_done++;
        if (exp_done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done got id %0d expected no done", done_id);
        end else begin
          d = exp_done_q.pop_front();
          chk("done_id", int'(done_id), d.id);
          chk("done_grant", int'(grant), 1 << d.id);
          chk_rng("burst_len", cyc - grant_cyc, d.lo, d.hi);
        end
      end
      prev_grant = grant;
    end
  endtask

  task automatic set_inputs(logic [3:0] mask, int hp, int b);
    req = mask;
    for (int i = 0; i < NR; i++) begin
      half_period[i*8 +: 8] = 8'(hp);
      blinks[i*4 +: 4]      = 4'(b);
    end
  endtask

  // Expected owners for a held mask, following the round-robin pointer.
  task automatic push_burst(logic [3:0] mask, int hp, int b, int ngr);
    int o, hpe;
    hpe = (hp == 0) ? 1 : hp;
    for (int g = 0; g < ngr; g++) begin
      o = -1;
      for (int k = NR - 1; k >= 0; k--)
        if (mask[(rr_m + k) % NR]) o = (rr_m + k) % NR;
      exp_grant_q.push_back(o);
      if (b != 0) exp_done_q.push_back('{id: o, lo: 8*b*hpe - 3, hi: 8*b*hpe});
      rr_m = (o + 1) % NR;
    end
  endtask

  task automatic wait_done(int target, int budget, string nm);
    int k = 0;
    while (n_done < target && k < budget) begin step(); k++; end
    if (n_done < target) begin
      checks++; errors++;
      $display("FAIL %s_timeout got %0d dones expected %0d", nm, n_done, target);
    end
  endtask

  task automatic wait_idle(int budget, string nm);
    int k = 0;
    while (busy && k < budget) begin step(); k++; end
    chk(nm, int'(busy), 0);
  endtask

  task automatic run_row(vec_t v);
    int hpe;
    hpe = (v.hp == 0) ? 1 : v.hp;
    set_inputs(v.req, v.hp, v.b);
    push_burst(v.req, v.hp, v.b, v.ngr);
    wait_done(n_done + v.ngr, v.ngr * (8*v.b*hpe + 40) + 40, "row");
    req = '0;
    wait_idle(40, "row_idle");
    chk("row_grants_left", exp_grant_q.size(), 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   runs[$];
    int   run_lo[6];
    int   run_hi[6];
    int   cur, k, d0, g0, rises;
    logic lv, started, pled;

    vecs[0] = '{req: 4'b1111, hp: 1, b: 1,  ngr: 5};
    vecs[1] = '{req: 4'b0100, hp: 0, b: 2,  ngr: 1};
    vecs[2] = '{req: 4'b0110, hp: 3, b: 1,  ngr: 2};
    vecs[3] = '{req: 4'b1001, hp: 2, b: 2,  ngr: 3};
    vecs[4] = '{req: 4'b0010, hp: 1, b: 15, ngr: 1};
    run_lo = '{5, 8, 8, 8, 8, 9};
    run_hi = '{8, 8, 8, 8, 8, 9};

    // Power-up reset, asserted away from any clock edge.
    #2 rst_n = 1'b0;
    #1;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_led", int'(led), 0);
    chk("rst_done", int'(done), 0);
    repeat (3) step();
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_row(vecs[i]);

    // Requester 0, hp=2, three blinks: exact phase lengths and GAP drain.
    set_inputs(4'b0001, 2, 3);
    push_burst(4'b0001, 2, 3, 1);
    runs.delete();
    cur = 0; lv = 1'b1; started = 1'b0; k = 0; d0 = n_done;
    while (n_done == d0 && k < 120) begin
      step(); k++;
      if (led) started = 1'b1;
      if (started) begin
        if (led == lv) cur++;
        else begin runs.push_back(cur); cur = 1; lv = led; end
      end
    end
    runs.push_back(cur);
    req = '0;
    chk("b_run_count", runs.size(), 6);
    for (int i = 0; i < runs.size() && i < 6; i++)
      chk_rng($sformatf("b_run%0d", i), runs[i], run_lo[i], run_hi[i]);
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 1) chk("b_done_width", int'(done), 0);
      if (j == 7) chk("b_gap_busy", int'(busy), 1);
      if (j == 8) chk("b_gap_end", int'(busy), 0);
    end

    // Inputs changed mid-burst must not affect the latched burst.
    set_inputs(4'b1000, 1, 2);
    push_burst(4'b1000, 1, 2, 1);
    g0 = n_grant; k = 0;
    while (n_grant == g0 && k < 10) begin step(); k++; end
    chk("e_granted", n_grant - g0, 1);
    half_period = {8'd5, 24'($urandom)};
    blinks      = {4'd7, 12'($urandom)};
    wait_done(n_done + 1, 60, "e");
    req = '0;
    wait_idle(40, "e_idle");

    // Continuous burst ended by abort: two ON entries in 30 cycles.
    set_inputs(4'b0001, 3, 0);
    push_burst(4'b0001, 3, 0, 1);
    rises = 0; pled = led;
    for (int j = 0; j < 30; j++) begin
      step();
      if (led && !pled) rises++;
      pled = led;
    end
    chk("c_rises", rises, 2);
    chk("c_grant_held", int'(grant), 1);
    req = '0;
    step();
    chk("c_abort_led", int'(led), 0);
    chk("c_abort_grant", int'(grant), 0);
    chk("c_abort_busy", int'(busy), 1);
    wait_idle(40, "c_idle");

    // Reset in the middle of an ON phase.
    set_inputs(4'b0100, 3, 2);
    push_burst(4'b0100, 3, 2, 1);
    k = 0;
    while (!led && k < 10) begin step(); k++; end
    chk("d_led_on", int'(led), 1);
    step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("d_rst_grant", int'(grant), 0);
    chk("d_rst_busy", int'(busy), 0);
    chk("d_rst_led", int'(led), 0);
    chk("d_rst_done", int'(done), 0);
    chk("d_rst_done_id", int'(done_id), 0);
    exp_grant_q.delete();
    exp_done_q.delete();
    rr_m = 0;
    req = '0;
    repeat (3) step();
    rst_n = 1'b1;
    run_row('{req: 4'b1101, hp: 1, b: 1, ngr: 1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
